// File: rtl/micro_sequencer_pkg.sv
// micro_sequencer_pkg: condition encodings and PSR bit positions for the ARC micro-sequencer
package micro_sequencer_pkg;
  localparam int COND_NEXT   = 0;
  localparam int COND_JN     = 1;
  localparam int COND_JZ     = 2;
  localparam int COND_JC     = 3;
  localparam int COND_JV     = 4;
  localparam int COND_JIR13  = 5;
  localparam int COND_JUMP   = 6;
  localparam int COND_DECODE = 7;
  localparam int COND_CALL   = 8;
  localparam int COND_RET    = 9;
  localparam int COND_WAIT   = 10;
  localparam int COND_JNZ    = 11;
  localparam int PSR_N = 3;
  localparam int PSR_Z = 2;
  localparam int PSR_V = 1;
  localparam int PSR_C = 0;
endpackage

// File: rtl/micro_stack.sv
// micro_stack: parametrised LIFO holding micro-return addresses, with full/empty flags
module micro_stack #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] pushData,
  output logic [WIDTH-1:0] topData,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [2**PW];
  logic [PW-1:0] ptr;
  logic [PW-1:0] topIdx;
  assign full = ptr == PW'(DEPTH);
  assign empty = ptr == '0;
  assign topIdx = ptr - 1'b1;
  assign topData = mem[topIdx];
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (push && !full) ptr <= ptr + 1'b1;
    else if (pop && !empty) ptr <= ptr - 1'b1;
  end
  always_ff @(posedge clk)
    if (!rst && push && !full) mem[ptr] <= pushData;
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: next control-store address select (next/jump/decode/call/ret/wait).
// Define MICRO_SEQUENCER_STACK_EN to build the micro-return stack; otherwise CALL=JUMP, RET=NEXT.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int DATAWIDTH_ADDRESS   = 11,
  parameter int DATAWIDTH_DECODEROP = 8,
  parameter int DATAWIDTH_COND      = 4,
  parameter int STACK_DEPTH         = 4,
  parameter int RESET_ADDRESS       = 0
) (
  input  logic                           MICRO_SEQUENCER_CLOCK_50,
  input  logic                           MICRO_SEQUENCER_ResetInHigh_In,
  input  logic [DATAWIDTH_COND-1:0]      MICRO_SEQUENCER_Condition_InBus,
  input  logic [DATAWIDTH_ADDRESS-1:0]   MICRO_SEQUENCER_JumpAddress_InBus,
  input  logic [DATAWIDTH_DECODEROP-1:0] MICRO_SEQUENCER_DecodeOp_InBus,
  input  logic                           MICRO_SEQUENCER_IR13_In,
  input  logic [3:0]                     MICRO_SEQUENCER_Psr_InBus,
  input  logic                           MICRO_SEQUENCER_ACK_In,
  output logic [DATAWIDTH_ADDRESS-1:0]   MICRO_SEQUENCER_CSAddress_OutBus,
  output logic                           MICRO_SEQUENCER_Stall_Out,
  output logic                           MICRO_SEQUENCER_StackError_Out
);
  localparam logic [DATAWIDTH_ADDRESS-1:0] RST_ADDR = DATAWIDTH_ADDRESS'(RESET_ADDRESS);
  logic [DATAWIDTH_ADDRESS-1:0] csReg, incAddr, decodeAddr, retAddr, nextAddr;
  logic [3:0] psr;
  logic isWait, isCall, isRet, isDecode, jumpTaken, stackErr;
  int cond;
  assign cond = int'(MICRO_SEQUENCER_Condition_InBus);
  assign psr = MICRO_SEQUENCER_Psr_InBus;
  always_comb begin
    incAddr = csReg + 1'b1;
    decodeAddr = (DATAWIDTH_ADDRESS'(1) << (DATAWIDTH_ADDRESS - 1))
               | (DATAWIDTH_ADDRESS'(MICRO_SEQUENCER_DecodeOp_InBus) << 2);
    isWait = cond == COND_WAIT;
    isCall = cond == COND_CALL;
    isRet = cond == COND_RET;
    isDecode = cond == COND_DECODE;
    jumpTaken = (cond == COND_JN && psr[PSR_N]) || (cond == COND_JZ && psr[PSR_Z])
             || (cond == COND_JC && psr[PSR_C]) || (cond == COND_JV && psr[PSR_V])
             || (cond == COND_JIR13 && MICRO_SEQUENCER_IR13_In) || cond == COND_JUMP
             || (cond == COND_JNZ && !psr[PSR_Z]);
    nextAddr = isWait ? (MICRO_SEQUENCER_ACK_In ? incAddr : csReg)
             : (jumpTaken || isCall) ? MICRO_SEQUENCER_JumpAddress_InBus
             : isDecode ? decodeAddr
             : isRet ? retAddr : incAddr;
  end
`ifdef MICRO_SEQUENCER_STACK_EN
  logic [DATAWIDTH_ADDRESS-1:0] topData;
  logic full, empty;
  micro_stack #(.WIDTH(DATAWIDTH_ADDRESS), .DEPTH(STACK_DEPTH)) stack (
    .clk(MICRO_SEQUENCER_CLOCK_50),
    .rst(MICRO_SEQUENCER_ResetInHigh_In),
    .push(isCall),
    .pop(isRet),
    .pushData(incAddr),
    .topData(topData),
    .full(full),
    .empty(empty)
  );
  assign retAddr = empty ? RST_ADDR : topData;
  always_ff @(posedge MICRO_SEQUENCER_CLOCK_50) begin
    if (MICRO_SEQUENCER_ResetInHigh_In) stackErr <= 1'b0;
    else if ((isCall && full) || (isRet && empty)) stackErr <= 1'b1;
  end
`else
  assign retAddr = incAddr;
  assign stackErr = 1'b0;
`endif
  always_ff @(posedge MICRO_SEQUENCER_CLOCK_50) begin
    if (MICRO_SEQUENCER_ResetInHigh_In) csReg <= RST_ADDR;
    else csReg <= nextAddr;
  end
  assign MICRO_SEQUENCER_CSAddress_OutBus = csReg;
  assign MICRO_SEQUENCER_Stall_Out = isWait && !MICRO_SEQUENCER_ACK_In && !MICRO_SEQUENCER_ResetInHigh_In;
  assign MICRO_SEQUENCER_StackError_Out = stackErr;
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed vectors with a scoreboard queue checked by a decoupled monitor
module tb_micro_sequencer;
  logic clk = 1'b0, rst = 1'b1, ir13 = 1'b0, ack = 1'b0;
  logic [3:0] cond = '0, psr = '0;
  logic [10:0] jump = '0, csOut;
  logic [7:0] op = '0;
  logic stall, stackErr;
  int errors = 0, checks = 0;
  typedef struct {
    string name;
    logic [10:0] cs;
    logic stall;
    logic err;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  micro_sequencer dut (
    .MICRO_SEQUENCER_CLOCK_50(clk),
    .MICRO_SEQUENCER_ResetInHigh_In(rst),
    .MICRO_SEQUENCER_Condition_InBus(cond),
    .MICRO_SEQUENCER_JumpAddress_InBus(jump),
    .MICRO_SEQUENCER_DecodeOp_InBus(op),
    .MICRO_SEQUENCER_IR13_In(ir13),
    .MICRO_SEQUENCER_Psr_InBus(psr),
    .MICRO_SEQUENCER_ACK_In(ack),
    .MICRO_SEQUENCER_CSAddress_OutBus(csOut),
    .MICRO_SEQUENCER_Stall_Out(stall),
    .MICRO_SEQUENCER_StackError_Out(stackErr)
  );
  task automatic step(input string name, input logic r, input logic [3:0] c, input logic [10:0] j,
                      input logic [7:0] o, input logic i, input logic [3:0] p, input logic a,
                      input logic [10:0] eCs, input logic eStall, input logic eErr);
    exp_t e;
    @(negedge clk);
    rst = r; cond = c; jump = j; op = o; ir13 = i; psr = p; ack = a;
    e.name = name; e.cs = eCs; e.stall = eStall; e.err = eErr;
    sb.push_back(e);
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (csOut !== e.cs || stall !== e.stall || stackErr !== e.err) begin
        errors++;
        $display("FAIL %s: cs=%h stall=%b err=%b expected cs=%h stall=%b err=%b",
                 e.name, csOut, stall, stackErr, e.cs, e.stall, e.err);
      end
    end
  end
  initial begin
    step("reset", 1, 0, 0, 0, 0, 0, 0, 11'h000, 0, 0);
    step("resetWait", 1, 10, 0, 0, 0, 0, 0, 11'h000, 0, 0);
    step("next1", 0, 0, 0, 0, 0, 0, 0, 11'h001, 0, 0);
    step("next2", 0, 0, 0, 0, 0, 0, 0, 11'h002, 0, 0);
    step("next3", 0, 0, 0, 0, 0, 0, 0, 11'h003, 0, 0);
    step("jumpTop", 0, 6, 11'h7FF, 0, 0, 0, 0, 11'h7FF, 0, 0);
    step("wrap", 0, 0, 0, 0, 0, 0, 0, 11'h000, 0, 0);
    step("jumpFF", 0, 6, 11'h0FF, 0, 0, 0, 0, 11'h0FF, 0, 0);
    step("jzTaken", 0, 2, 11'h100, 0, 0, 4'b0100, 0, 11'h100, 0, 0);
    step("jzNot", 0, 2, 11'h100, 0, 0, 4'b1011, 0, 11'h101, 0, 0);
    step("jnzTaken", 0, 11, 11'h100, 0, 0, 4'b0000, 0, 11'h100, 0, 0);
    step("jnzNot", 0, 11, 11'h300, 0, 0, 4'b0100, 0, 11'h101, 0, 0);
    step("jnTaken", 0, 1, 11'h050, 0, 0, 4'b1000, 0, 11'h050, 0, 0);
    step("jnNot", 0, 1, 11'h300, 0, 0, 4'b0111, 0, 11'h051, 0, 0);
    step("jcTaken", 0, 3, 11'h060, 0, 0, 4'b0001, 0, 11'h060, 0, 0);
    step("jcNot", 0, 3, 11'h300, 0, 0, 4'b1110, 0, 11'h061, 0, 0);
    step("jvTaken", 0, 4, 11'h070, 0, 0, 4'b0010, 0, 11'h070, 0, 0);
    step("jvNot", 0, 4, 11'h300, 0, 0, 4'b1101, 0, 11'h071, 0, 0);
    step("jirTaken", 0, 5, 11'h080, 0, 1, 0, 0, 11'h080, 0, 0);
    step("jirNot", 0, 5, 11'h300, 0, 0, 4'b1111, 0, 11'h081, 0, 0);
    step("decode81", 0, 7, 11'h300, 8'h81, 0, 0, 0, 11'h604, 0, 0);
    step("decode3C", 0, 7, 11'h300, 8'h3C, 0, 0, 0, 11'h4F0, 0, 0);
    step("resv12", 0, 12, 11'h300, 0, 0, 4'b1111, 0, 11'h4F1, 0, 0);
    step("resv15", 0, 15, 11'h300, 0, 1, 4'b1111, 0, 11'h4F2, 0, 0);
    for (int i = 0; i < 3; i++) step("waitHold", 0, 10, 11'h300, 0, 0, 0, 0, 11'h4F2, 1, 0);
    step("waitAck", 0, 10, 11'h300, 0, 0, 0, 1, 11'h4F3, 0, 0);
    step("waitHold2", 0, 10, 11'h300, 0, 0, 0, 0, 11'h4F3, 1, 0);
    step("resetMidWait", 1, 10, 11'h300, 0, 0, 0, 0, 11'h000, 0, 0);
    step("to010", 0, 6, 11'h010, 0, 0, 0, 0, 11'h010, 0, 0);
`ifdef MICRO_SEQUENCER_STACK_EN
    step("call200", 0, 8, 11'h200, 0, 0, 0, 0, 11'h200, 0, 0);
    step("ret011", 0, 9, 11'h300, 0, 0, 0, 0, 11'h011, 0, 0);
    step("call1", 0, 8, 11'h100, 0, 0, 0, 0, 11'h100, 0, 0);
    step("call2", 0, 8, 11'h110, 0, 0, 0, 0, 11'h110, 0, 0);
    step("call3", 0, 8, 11'h120, 0, 0, 0, 0, 11'h120, 0, 0);
    step("call4", 0, 8, 11'h130, 0, 0, 0, 0, 11'h130, 0, 0);
    step("callFull", 0, 8, 11'h140, 0, 0, 0, 0, 11'h140, 0, 1);
    step("ret4", 0, 9, 11'h300, 0, 0, 0, 0, 11'h121, 0, 1);
    step("ret3", 0, 9, 11'h300, 0, 0, 0, 0, 11'h111, 0, 1);
    step("ret2", 0, 9, 11'h300, 0, 0, 0, 0, 11'h101, 0, 1);
    step("ret1", 0, 9, 11'h300, 0, 0, 0, 0, 11'h012, 0, 1);
    step("retEmpty", 0, 9, 11'h300, 0, 0, 0, 0, 11'h000, 0, 1);
    step("errHeld", 0, 0, 11'h300, 0, 0, 0, 0, 11'h001, 0, 1);
    step("callPre", 0, 8, 11'h250, 0, 0, 0, 0, 11'h250, 0, 1);
    step("resetMidCall", 1, 8, 11'h260, 0, 0, 0, 0, 11'h000, 0, 0);
    step("retAfterRst", 0, 9, 11'h300, 0, 0, 0, 0, 11'h000, 0, 1);
    step("clearErr", 1, 0, 0, 0, 0, 0, 0, 11'h000, 0, 0);
`else
    step("callAsJump", 0, 8, 11'h200, 0, 0, 0, 0, 11'h200, 0, 0);
    step("retAsNext", 0, 9, 11'h300, 0, 0, 0, 0, 11'h201, 0, 0);
    step("retEmptyNext", 0, 9, 11'h300, 0, 0, 0, 0, 11'h202, 0, 0);
`endif
    step("afterAll", 0, 0, 0, 0, 0, 0, 0, sb.size() == 0 ? 11'h000 : 11'h000, 0, 0);
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Parametrised microprogram sequencer for the ARC microcoded control path: each clock it selects the next control-store address from increment, MIR jump field, opcode decode, or a micro-return stack. Branch conditions come from the PSR flags and IR bit 13. It adds micro-subroutine call/return and an ACK wait state to the existing next/jump/decode sequencing. It sits between the MIR condition/jump fields and the control-store address input.

## Interface
- DATAWIDTH_ADDRESS, 11, control-store address width; must be ≥ DATAWIDTH_DECODEROP+3
- DATAWIDTH_DECODEROP, 8, opcode bits used for decode dispatch
- DATAWIDTH_COND, 4, MIR condition field width
- STACK_DEPTH, 4, micro-return stack entries (≥1)
- RESET_ADDRESS, 0, control-store address after reset
- MICRO_SEQUENCER_CLOCK_50  in  1  single clock; all state on rising edge
- MICRO_SEQUENCER_ResetInHigh_In  in  1  reset, synchronous and active-high
- MICRO_SEQUENCER_Condition_InBus  in  DATAWIDTH_COND  MIR condition field
- MICRO_SEQUENCER_JumpAddress_InBus  in  DATAWIDTH_ADDRESS  MIR jump address
- MICRO_SEQUENCER_DecodeOp_InBus  in  DATAWIDTH_DECODEROP  opcode bits from IR
- MICRO_SEQUENCER_IR13_In  in  1  IR bit 13
- MICRO_SEQUENCER_Psr_InBus  in  4  {N,Z,V,C}
- MICRO_SEQUENCER_ACK_In  in  1  memory acknowledge
- MICRO_SEQUENCER_CSAddress_OutBus  out  DATAWIDTH_ADDRESS  current control-store address (registered)
- MICRO_SEQUENCER_Stall_Out  out  1  high while a WAIT holds the address
- MICRO_SEQUENCER_StackError_Out  out  1  sticky stack overflow/underflow flag

## Operation
- CS = current address; NEXT = CS+1, wrapping from all-ones to 0.
- Condition encodings: 0 NEXT; 1 JUMP if N; 2 JUMP if Z; 3 JUMP if C; 4 JUMP if V; 5 JUMP if IR13; 6 JUMP always; 7 DECODE; 8 CALL; 9 RET; 10 WAIT; 11 JUMP if not Z; 12–15 reserved, act as NEXT.
- Conditional jump: condition true → JumpAddress, else NEXT.
- DECODE: address = {1, zeros, DecodeOp, 2'b00}, zero-padded to DATAWIDTH_ADDRESS.
- CALL: push NEXT, go to JumpAddress. If stack full: go to JumpAddress, drop push, set StackError.
- RET: pop top. If stack empty: go to RESET_ADDRESS, set StackError.
- WAIT: ACK low → CS held, Stall_Out=1; ACK high → NEXT, Stall_Out=0.
- Stack pointer width $clog2(STACK_DEPTH+1). One stack op per cycle, so push and pop never coincide.
- StackError clears only on reset.

## Timing
- Reset (sampled at edge): CS=RESET_ADDRESS, stack pointer 0, StackError=0. Stall_Out is forced 0 while reset is high. Reset wins over any condition, including mid-WAIT and mid-CALL.
- One microinstruction per cycle: the inputs present during cycle t select CS for cycle t+1 (1-cycle latency).
- Stall_Out is combinational: (Condition==WAIT) & ~ACK & ~reset.
- CALL at t followed by RET at t+k: RET returns the CALL address+1 at edge t+k.
- Psr and IR13 are sampled in the same cycle as the condition; this block adds no flag pipelining.

## Configuration
- MICRO_SEQUENCER_STACK_EN defined: micro-return stack, CALL/RET and StackError behave as above.
- Not defined: no stack storage; CALL acts as JUMP always, RET acts as NEXT, StackError tied 0.

## Structure
- Package micro_sequencer_pkg: condition encoding localparams (COND_NEXT … COND_JNZ) and the PSR bit indices N=3, Z=2, V=1, C=0.
- Sub-module micro_stack: parametrised LIFO with push, pop, full and empty flags. It is instantiated only under MICRO_SEQUENCER_STACK_EN.

## Test plan
- Reset with RESET_ADDRESS=0, then cond=0 for 3 cycles → CS 0,1,2,3; CS=2047 with NEXT → 0.
- cond=2, Jump=0x100, Z=1 → CS=0x100; Z=0 → CS+1; cond=11 with Z=0 → 0x100.
- cond=7, DecodeOp=0x81 → CS=0x604 (11-bit width).
- CALL 0x200 from CS=0x010, then RET from 0x200 → CS 0x200 then 0x011. Nested depth 4 unwinds correctly; a fifth CALL sets StackError and still jumps.
- RET on empty stack → CS=RESET_ADDRESS, StackError=1, held until reset.
- WAIT with ACK low for 3 cycles → CS held, Stall=1. ACK high → CS+1, Stall=0. Reset asserted mid-WAIT → CS=RESET_ADDRESS next edge.
